// File: rtl/serial_word_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_collector_pkg
// Description : Shared constants for the serial word collector.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_word_collector_pkg;

  // Word width matches the upstream 8-bit shift stage.
  localparam int C_DATA_W = 8;
  localparam int C_CNT_W  = 4;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

endpackage : serial_word_collector_pkg
`default_nettype wire

// File: rtl/serial_word_collector_slot.sv
`default_nettype none
// ============================================================================
// Module      : word_out_slot
// Description : Single-entry valid/ready holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module word_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_load_accepted
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_slot_free;

  // Slot is free when empty or being drained this very cycle.
  assign w_slot_free     = ~r_valid | i_ready;
  assign o_load_accepted = i_load & w_slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_load_accepted) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : word_out_slot
`default_nettype wire

// File: rtl/serial_word_collector.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_collector
// Description : Reassembles a serial bit stream into DATA_W-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_collector
  import serial_word_collector_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int CNT_W  = C_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_bit_in,
  input  logic              i_bit_valid,
  input  logic              i_msb_first,
  input  logic              i_frame_abort,
  output logic [DATA_W-1:0] o_word_out,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic [CNT_W-1:0]  o_bit_count,
  output logic              o_overflow,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(DATA_W - 1);

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_count;
  logic              r_order;
  logic              r_overflow;

  logic [DATA_W-1:0] w_first_bits;
  logic [DATA_W-1:0] w_shift_next;
  logic              w_last_bit;
  logic              w_complete;
  logic              w_load_accepted;

  // First bit of a word uses the live order input; later bits use the captured one.
  assign w_first_bits = i_msb_first ? {{(DATA_W-1){1'b0}}, i_bit_in}
                                    : {i_bit_in, {(DATA_W-1){1'b0}}};
  assign w_shift_next = r_order ? {r_shreg[DATA_W-2:0], i_bit_in}
                                : {i_bit_in, r_shreg[DATA_W-1:1]};

  assign w_last_bit = (r_count == C_LAST_CNT);
  assign w_complete = (r_state == ST_COLLECT) & i_bit_valid & w_last_bit & ~i_frame_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_count    <= '0;
      r_order    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_complete && !w_load_accepted) begin
        r_overflow <= 1'b1;
      end
      if (i_frame_abort) begin
        r_state <= ST_IDLE;
        r_shreg <= '0;
        r_count <= '0;
      end else if (i_bit_valid) begin
        case (r_state)
          ST_IDLE: begin
            r_order <= i_msb_first;
            r_shreg <= w_first_bits;
            r_count <= CNT_W'(1);
            r_state <= ST_COLLECT;
          end
          ST_COLLECT: begin
            r_shreg <= w_shift_next;
            if (w_last_bit) begin
              r_count <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end
        endcase
      end
    end
  end

  word_out_slot #(
    .DATA_W (DATA_W)
  ) u_slot (
    .clk             (clk),
    .rst             (rst),
    .i_load          (w_complete),
    .i_load_data     (w_shift_next),
    .i_ready         (i_word_ready),
    .o_valid         (o_word_valid),
    .o_data          (o_word_out),
    .o_load_accepted (w_load_accepted)
  );

  assign o_bit_count = r_count;
  assign o_overflow  = r_overflow;
  assign o_busy      = (r_state == ST_COLLECT);

endmodule : serial_word_collector
`default_nettype wire

// File: tb/tb_serial_word_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_collector
// Description : Scoreboard bench for serial_word_collector.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_word_collector;

  logic       clk;
  logic       rst;
  logic       i_bit_in;
  logic       i_bit_valid;
  logic       i_msb_first;
  logic       i_frame_abort;
  logic [7:0] o_word_out;
  logic       o_word_valid;
  logic       i_word_ready;
  logic [3:0] o_bit_count;
  logic       o_overflow;
  logic       o_busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_q[$];

  serial_word_collector #(.DATA_W(8), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_bit_in      (i_bit_in),
    .i_bit_valid   (i_bit_valid),
    .i_msb_first   (i_msb_first),
    .i_frame_abort (i_frame_abort),
    .o_word_out    (o_word_out),
    .o_word_valid  (o_word_valid),
    .i_word_ready  (i_word_ready),
    .o_bit_count   (o_bit_count),
    .o_overflow    (o_overflow),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transfers are observed mid-cycle, while ready is stable.
  always @(negedge clk) begin
    if (!rst && o_word_valid && i_word_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_word", {31'd0, o_word_valid}, 32'd0);
      end else begin
        chk("sb_word", {24'd0, o_word_out}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    i_bit_valid = 1'b1;
    i_bit_in    = b;
    tick();
    i_bit_valid = 1'b0;
    i_bit_in    = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic msb, input int gap);
    i_msb_first = msb;
    for (int i = 0; i < 8; i++) begin
      drive_bit(msb ? w[7-i] : w[i]);
      if (i != 7) begin
        for (int g = 0; g < gap; g++) begin
          i_bit_in = 1'bx;
          tick();
        end
        i_bit_in = 1'b0;
      end
    end
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    rst = 1'b1;
    i_bit_in = 1'b0;
    i_bit_valid = 1'b0;
    i_msb_first = 1'b1;
    i_frame_abort = 1'b0;
    i_word_ready = 1'b1;
    #1;
    chk("rst_word_out", {24'd0, o_word_out}, 32'h0);
    chk("rst_valid", {31'd0, o_word_valid}, 32'd0);
    chk("rst_count", {28'd0, o_bit_count}, 32'd0);
    chk("rst_overflow", {31'd0, o_overflow}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: MSB-first A5, one-cycle latency, single-cycle valid
    pat = 8'hA5;
    i_msb_first = 1'b1;
    sb_q.push_back(8'hA5);
    for (int i = 0; i < 7; i++) drive_bit(pat[7-i]);
    chk("t1_busy_before_last", {31'd0, o_busy}, 32'd1);
    chk("t1_count_before_last", {28'd0, o_bit_count}, 32'd7);
    chk("t1_valid_before_last", {31'd0, o_word_valid}, 32'd0);
    drive_bit(pat[0]);
    chk("t1_valid_latency", {31'd0, o_word_valid}, 32'd1);
    chk("t1_word", {24'd0, o_word_out}, 32'hA5);
    chk("t1_idle_after", {31'd0, o_busy}, 32'd0);
    tick();
    chk("t1_valid_one_cycle", {31'd0, o_word_valid}, 32'd0);

    // 2: LSB-first bits 1,1,0,0,0,0,0,0 -> 03
    sb_q.push_back(8'h03);
    send_word(8'h03, 1'b0, 0);
    chk("t2_word", {24'd0, o_word_out}, 32'h03);
    tick();

    // 3: backpressure and overflow
    i_word_ready = 1'b0;
    sb_q.push_back(8'h3C);
    send_word(8'h3C, 1'b1, 0);
    chk("t3_ovf_before", {31'd0, o_overflow}, 32'd0);
    send_word(8'hC3, 1'b1, 0);
    tick();
    chk("t3_word_held", {24'd0, o_word_out}, 32'h3C);
    chk("t3_valid_held", {31'd0, o_word_valid}, 32'd1);
    chk("t3_overflow", {31'd0, o_overflow}, 32'd1);
    i_word_ready = 1'b1;
    tick();
    chk("t3_valid_after_xfer", {31'd0, o_word_valid}, 32'd0);
    chk("t3_overflow_sticky", {31'd0, o_overflow}, 32'd1);

    // 4: completion coinciding with accept
    sync_reset();
    i_word_ready = 1'b0;
    sb_q.push_back(8'h11);
    send_word(8'h11, 1'b1, 0);
    pat = 8'h22;
    sb_q.push_back(8'h22);
    for (int i = 0; i < 7; i++) drive_bit(pat[7-i]);
    i_word_ready = 1'b1;
    drive_bit(pat[0]);
    chk("t4_valid_stays", {31'd0, o_word_valid}, 32'd1);
    chk("t4_word_new", {24'd0, o_word_out}, 32'h22);
    chk("t4_no_overflow", {31'd0, o_overflow}, 32'd0);
    tick();
    chk("t4_drained", {31'd0, o_word_valid}, 32'd0);

    // 5: abort mid-word, with a coincident bit_valid that must be ignored
    i_msb_first = 1'b1;
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    chk("t5_count_5", {28'd0, o_bit_count}, 32'd5);
    i_frame_abort = 1'b1;
    drive_bit(1'b1);
    i_frame_abort = 1'b0;
    chk("t5_abort_count", {28'd0, o_bit_count}, 32'd0);
    chk("t5_abort_busy", {31'd0, o_busy}, 32'd0);
    chk("t5_abort_valid", {31'd0, o_word_valid}, 32'd0);
    sb_q.push_back(8'hF0);
    send_word(8'hF0, 1'b1, 0);
    chk("t5_word", {24'd0, o_word_out}, 32'hF0);
    tick();

    // 6a: gaps with X on bit_in while bit_valid is low
    sb_q.push_back(8'hA5);
    send_word(8'hA5, 1'b1, 2);
    chk("t6_gap_word", {24'd0, o_word_out}, 32'hA5);
    tick();
    chk("t6_gap_count", {28'd0, o_bit_count}, 32'd0);

    // 6b: asynchronous reset between edges
    i_word_ready = 1'b0;
    send_word(8'h5A, 1'b1, 0);
    send_word(8'h0F, 1'b1, 0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    chk("t6_pre_rst_word", {24'd0, o_word_out}, 32'h5A);
    chk("t6_pre_rst_ovf", {31'd0, o_overflow}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_arst_word", {24'd0, o_word_out}, 32'h0);
    chk("t6_arst_valid", {31'd0, o_word_valid}, 32'd0);
    chk("t6_arst_count", {28'd0, o_bit_count}, 32'd0);
    chk("t6_arst_overflow", {31'd0, o_overflow}, 32'd0);
    chk("t6_arst_busy", {31'd0, o_busy}, 32'd0);
    tick();
    rst = 1'b0;
    i_word_ready = 1'b1;
    tick();
    tick();

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_word_collector
`default_nettype wire

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream stage of the 8-bit shift register.
- Consumes the serial_out bit stream and reassembles it into parallel words of DATA_W bits.
- Presents each completed word on a valid/ready output port. The output holding register lets one word wait for the consumer while the next word is being shifted in.
- Flags lost words and framing aborts for the system controller.

Parameters:
- DATA_W, 8, word width in bits; must be 2 or more.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial bit from the shift stage (its serial_out); sampled only when bit_valid=1.
- bit_valid  input  1  bit_in carries a real data bit this cycle; driven high only for shift/rotate ops.
- msb_first  input  1  1: first received bit lands in word_out[DATA_W-1]; 0: first bit lands in word_out[0]. Sampled at the first bit of each word.
- frame_abort  input  1  discard the partially assembled word.
- word_out  output  DATA_W  completed word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out when word_valid & word_ready.
- bit_count  output  CNT_W  bits collected so far in the current word (0..DATA_W-1).
- overflow  output  1  sticky; a completed word was dropped.
- busy  output  1  the collector is in state COLLECT.

Behaviour:
- Reset (asynchronous, immediate) values:
  - word_out=0, word_valid=0, bit_count=0, overflow=0, busy=0.
  - State=IDLE; internal shift register=0; captured order bit=1.
- States:
  - IDLE: no partial word.
  - COLLECT: 1..DATA_W-1 bits held.
- IDLE, bit_valid=1:
  - Capture msb_first.
  - Store bit_in; bit_count<=1; go to COLLECT.
- COLLECT, bit_valid=1, bit_count<DATA_W-1:
  - Shift bit_in in; bit_count increments.
  - MSB-first: shreg<={shreg[DATA_W-2:0],bit_in}.
  - LSB-first: shreg<={bit_in,shreg[DATA_W-1:1]}.
- Word completion (bit_count=DATA_W-1 and bit_valid=1):
  - The completed word is the shift result including this bit.
  - bit_count<=0; go to IDLE.
  - If the output slot is free (word_valid=0, or word_ready=1 this cycle): word_out<=completed word and word_valid=1 on the next cycle. Latency is 1 clock from the final bit to word_valid.
  - Otherwise: the completed word is dropped, word_out keeps the old word, and overflow<=1.
- Handshake:
  - Transfer happens on a cycle where word_valid & word_ready.
  - After a transfer, word_valid<=0 unless a new word completes in the same cycle; in that case word_valid stays 1 and word_out takes the new word.
  - word_out is stable while word_valid=1 and word_ready=0.
- bit_valid=0: no change to the shift register or bit_count. Gaps between bits are unlimited.
- X/Z on bit_in while bit_valid=0 must not propagate into any state.
- frame_abort=1:
  - shreg<=0, bit_count<=0, state<=IDLE.
  - A bit_valid in the same cycle is ignored.
  - word_out, word_valid and overflow are unaffected.
  - A completion in the same cycle is also aborted, so no word is produced.
- overflow clears only on rst.
- busy = (state==COLLECT).

Decomposition:
- Shared package/header holds:
  - state encoding constants ST_IDLE=1'b0, ST_COLLECT=1'b1;
  - DATA_W default 8, matching the shift stage width.
- One natural sub-module: word_out_slot.
  - Single-entry valid/ready holding register.
  - Inputs: load, load_data, ready. Outputs: valid, data, load_accepted.
  - Reusable for other stages of the pipeline.
- Deserialising FSM and counter live in the top module.

Test Plan:
1. MSB-first word: rst pulse, msb_first=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles with word_ready=1 -> word_out=8'hA5 and word_valid=1 exactly one clock after the 8th bit; valid for 1 cycle.
2. LSB-first word: same bit sequence with msb_first=0 -> word_out=8'hA5 bit-reversed = 8'hA5 is symmetric, so use bits 1,1,0,0,0,0,0,0 -> word_out=8'h03.
3. Backpressure and overflow:
   - word_ready=0; send word 8'h3C, then a full second word 8'hC3 -> word_out stays 8'h3C, overflow=1.
   - Then word_ready=1 -> one transfer of 8'h3C, word_valid=0 next cycle.
4. Simultaneous completion and accept: word_valid=1 (8'h11), word_ready=1 in the same cycle the 8th bit of 8'h22 arrives -> no overflow, word_out=8'h22, word_valid stays 1.
5. Abort mid-word:
   - 5 bits sent, then frame_abort=1 -> bit_count=0, busy=0.
   - Next 8 bits 8'hF0 -> word_out=8'hF0 with no leftover bits.
6. Gaps, X input and async reset:
   - bit_valid toggled with bit_in=1'bx during low phases -> word_out identical to the gap-free run.
   - rst asserted mid-word between clock edges -> all outputs 0 immediately, before the next clk edge.
